// File: rtl/wb_commit_pkg.sv
// -----------------------------------------------------------------------------
// wb_commit_pkg
// Shared definitions for the write-back/commit stage: the memory-to-write-back
// bus layout, stall-vector encoding, exception codes and the exception vector.
// -----------------------------------------------------------------------------
package wb_commit_pkg;

  localparam int MEM_TO_WB_WD = 274;

  // Stall vector: one bit per pipeline stage, Stop = 1.
  localparam int   STALL_W   = 9;
  localparam int   STALL_MEM = 7;
  localparam int   STALL_WB  = 8;
  localparam logic STOP      = 1'b1;
  localparam logic NO_STOP   = 1'b0;

  localparam logic [31:0] EXC_ERET    = 32'h0000_000E;
  localparam logic [31:0] EXC_REFETCH = 32'hFFFF_FFFF;
  localparam logic [31:0] EXC_VECTOR  = 32'hBFC0_0380;

  typedef struct packed {
    logic        we;
    logic [7:0]  waddr;   // {reg[4:0], sel[2:0]}
    logic [31:0] wdata;
  } cp0_bus_t;            // 41 bits

  typedef struct packed {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_bus_t;           // 66 bits

  // Field order is MSB first and matches the flat bus bit ranges.
  typedef struct packed {
    cp0_bus_t    cp0_bus;          // [273:233]
    logic [31:0] cp0_epc;          // [232:201]
    logic        is_in_delayslot;  // [200]
    logic [31:0] bad_vaddr;        // [199:168]
    logic [31:0] excepttype;       // [167:136]
    hilo_bus_t   hilo_bus;         // [135:70]
    logic [31:0] pc;               // [69:38]
    logic        rf_we;            // [37]
    logic [4:0]  rf_waddr;         // [36:32]
    logic [31:0] rf_wdata;         // [31:0]
  } mem_to_wb_t;

endpackage

// File: rtl/wb_commit_hilo_reg.sv
// -----------------------------------------------------------------------------
// hilo_reg
// HI/LO architectural registers with independent write enables. Read ports
// bypass the value being committed this cycle so a consumer sees it at once.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   hi_we_i, lo_we_i committed write enables (already qualified by the caller)
//   hi_i, lo_i       write data
//   hi_o, lo_o       bypassed read values
// -----------------------------------------------------------------------------
module hilo_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [31:0] hi_q, lo_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we_i) hi_q <= hi_i;
      if (lo_we_i) lo_q <= lo_i;
    end
  end

  assign hi_o = hi_we_i ? hi_i : hi_q;
  assign lo_o = lo_we_i ? lo_i : lo_q;

endmodule

// File: rtl/wb_commit.sv
// -----------------------------------------------------------------------------
// wb_commit
// Write-back/commit stage. Registers the memory-stage bus, then commits the
// instruction: GPR, HI/LO and CP0 writes (all suppressed on exception),
// precise-exception flush/redirect plus the exception record for CP0, and
// trace outputs.
// Ports:
//   clk, rst, flush, stall      clock, sync reset, global flush, stall vector
//   mem_to_wb_bus               274-bit bus from the memory stage
//   rf_we/rf_waddr/rf_wdata     GPR write port
//   hi_o, lo_o                  HI/LO read with same-cycle commit bypass
//   cp0_we/cp0_waddr/cp0_wdata  CP0 write port
//   excp_*                      flush, redirect PC and exception record
//   debug_wb_*                  trace
// -----------------------------------------------------------------------------
module wb_commit
  import wb_commit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [STALL_W-1:0]      stall,
  input  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [31:0]             rf_wdata,
  output logic [31:0]             hi_o,
  output logic [31:0]             lo_o,
  output logic                    cp0_we,
  output logic [7:0]              cp0_waddr,
  output logic [31:0]             cp0_wdata,
  output logic                    excp_flush,
  output logic [31:0]             excp_new_pc,
  output logic [31:0]             excp_type,
  output logic [31:0]             excp_pc,
  output logic [31:0]             excp_bad_vaddr,
  output logic                    excp_in_delayslot,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
);

  mem_to_wb_t wb_q, wb_d;
  logic       valid, exc, commit;

  // Bubbles carry pc = 0, so a zero pc marks an empty slot.
  assign valid  = (wb_q.pc != '0);
  assign exc    = valid & (wb_q.excepttype != '0);
  assign commit = valid & ~exc;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wb_d = wb_q;
    if (flush || exc) begin
      // An excepting instruction clears itself even under stall[8], so
      // excp_flush lasts exactly one cycle.
      wb_d = '0;
    end else if (stall[STALL_MEM] == STOP && stall[STALL_WB] == NO_STOP) begin
      wb_d = '0;
    end else if (stall[STALL_MEM] == NO_STOP) begin
      wb_d = mem_to_wb_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wb_q <= '0;
    else     wb_q <= wb_d;
  end

  hilo_reg u_hilo_reg (
    .clk     (clk),
    .rst     (rst),
    .hi_we_i (commit & wb_q.hilo_bus.hi_we),
    .lo_we_i (commit & wb_q.hilo_bus.lo_we),
    .hi_i    (wb_q.hilo_bus.hi),
    .lo_i    (wb_q.hilo_bus.lo),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  assign rf_we     = commit & wb_q.rf_we;
  assign rf_waddr  = wb_q.rf_waddr;
  assign rf_wdata  = wb_q.rf_wdata;

  assign cp0_we    = commit & wb_q.cp0_bus.we;
  assign cp0_waddr = wb_q.cp0_bus.waddr;
  assign cp0_wdata = wb_q.cp0_bus.wdata;

  always_comb begin
    excp_new_pc       = '0;
    excp_type         = '0;
    excp_pc           = '0;
    excp_bad_vaddr    = '0;
    excp_in_delayslot = 1'b0;
    if (exc) begin
      excp_type         = wb_q.excepttype;
      excp_pc           = wb_q.pc;
      excp_bad_vaddr    = wb_q.bad_vaddr;
      excp_in_delayslot = wb_q.is_in_delayslot;
      if (wb_q.excepttype == EXC_ERET)         excp_new_pc = wb_q.cp0_epc;
      else if (wb_q.excepttype == EXC_REFETCH) excp_new_pc = wb_q.pc;
      else                                     excp_new_pc = EXC_VECTOR;
    end
  end

  assign excp_flush        = exc;

  assign debug_wb_pc       = wb_q.pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = wb_q.rf_waddr;
  assign debug_wb_rf_wdata = wb_q.rf_wdata;

endmodule
